instr_fetch_seq: RTL and testbench

//  Fetch sequencer for the 8-bit-address, 16-bit-word combinational instruction ROM.
//  - Owns the program counter, drives the ROM address and registers each fetched word.
//  - Presents each word to the lane issue stage over a valid/ready handshake.
//  - Consumes the LOOP opcode (4'hF) itself and counts loop iterations.
//  - Sits between the ROM and the lane decode/ALU array; started and halted by the top controller.

---
 rtl/instr_fetch_seq.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer for the combinational instruction ROM.
// Owns the program counter, registers each fetched word and offers it to the
// issue stage over a valid/ready handshake. LOOP words are consumed here:
// they restart the program at address 0 and bump the loop counter, which can
// end the run after a programmed number of passes.
module instr_fetch_seq #(
    parameter int          ADDR_W  = 8,
    parameter int          INSTR_W = 16,
    parameter logic [3:0]  LOOP_OP = 4'hF,
    parameter int          CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic [CNT_W-1:0]   loop_limit,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   loop_cnt,
    output logic               busy,
    output logic               done
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0]  PC_ZERO    = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  PC_ONE     = ADDR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]     CNT_ONE_W  = (CNT_W+1)'(1);
    localparam logic [INSTR_W-1:0] INSTR_ZERO = {INSTR_W{1'b0}};

    // Saturating loop-count increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic               finish_q, finish_d;   // current drain ends in DONE, not IDLE

    logic transfer_s;
    logic fetch_slot_s;
    logic is_loop_s;
    logic limit_hit_s;

    assign transfer_s   = valid_q & instr_ready;
    assign fetch_slot_s = (state_q == ST_RUN) & (~valid_q | instr_ready);
    assign is_loop_s    = (rom_data[INSTR_W-1 -: 4] == LOOP_OP);
    // Compare one bit wider so a saturated counter never aliases onto a limit.
    assign limit_hit_s  = (loop_limit != CNT_ZERO) &&
                          (({1'b0, loop_cnt_q} + CNT_ONE_W) == {1'b0, loop_limit});

    // Next-state logic for FSM, PC, instruction register and loop counter.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        loop_cnt_d = loop_cnt_q;
        finish_d   = finish_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (transfer_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
                // halt has priority over start
                if (start && !halt) begin
                    state_d    = ST_RUN;
                    pc_d       = PC_ZERO;
                    loop_cnt_d = CNT_ZERO;
                    finish_d   = 1'b0;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    // No fetch in the halt cycle; only retire a word taken now.
                    state_d = ST_DRAIN;
                    if (transfer_s) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = valid_q;
                    end
                end else if (fetch_slot_s) begin
                    if (is_loop_s) begin
                        // LOOP is never issued; it costs one bubble.
                        pc_d       = PC_ZERO;
                        loop_cnt_d = sat_inc(loop_cnt_q);
                        if (instr_ready) begin
                            valid_d = 1'b0;
                        end else begin
                            valid_d = valid_q;
                        end
                        if (limit_hit_s) begin
                            state_d  = ST_DRAIN;
                            finish_d = 1'b1;
                        end else begin
                            state_d  = ST_RUN;
                        end
                    end else begin
                        instr_d = rom_data;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_ONE;   // wraps naturally at the top
                    end
                end else begin
                    // Stalled: held word waits for the issue stage.
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (transfer_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
                if (!valid_q) begin
                    if (finish_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; asynchronous reset drops any held word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= PC_ZERO;
            instr_q    <= INSTR_ZERO;
            valid_q    <= 1'b0;
            loop_cnt_q <= CNT_ZERO;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            loop_cnt_q <= loop_cnt_d;
            finish_q   <= finish_d;
        end
    end

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign loop_cnt    = loop_cnt_q;
    assign busy        = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: directed stimulus pushes the words
// expected on the issue port; a negedge monitor pops and compares each
// transfer. State/PC/loop counter are checked directly against hand values.
module tb_instr_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic [7:0]  loop_limit;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc;
    logic [7:0]  loop_cnt;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:255];
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;
    int          checks;
    int          errors;

    assign rom_data = rom[rom_addr];

    instr_fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .loop_limit(loop_limit), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .loop_cnt(loop_cnt), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h7132; rom[1] = 16'h111E; rom[2] = 16'h111C;
        rom[3] = 16'h0000; rom[4] = 16'h1010; rom[5] = 16'hF000;
    endtask

    task automatic push_pass();
        exp_q.push_back(16'h7132); exp_q.push_back(16'h111E);
        exp_q.push_back(16'h111C); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h1010);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h expected=none at %0t", instr, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("issue_word", {16'h0000, instr}, {16'h0000, mon_exp});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; halt = 1'b0;
        loop_limit = 8'd0; instr_ready = 1'b1;
        load_prog();
        #12;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_loopcnt", {24'd0, loop_cnt}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: free run, limit 0, two passes then halt
        push_pass(); push_pass();
        pulse_start();
        chk("t1_pc_start", {24'd0, pc}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_valid_c1", {31'd0, instr_valid}, 32'd0);
        step();
        chk("t1_first_instr", {16'd0, instr}, 32'h7132);
        steps(5);
        chk("t1_loopcnt1", {24'd0, loop_cnt}, 32'd1);
        chk("t1_bubble", {31'd0, instr_valid}, 32'd0);
        chk("t1_pc_loop", {24'd0, pc}, 32'd0);
        steps(6);
        chk("t1_loopcnt2", {24'd0, loop_cnt}, 32'd2);
        halt = 1'b1;
        step();
        chk("t1_drain_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_idle", {30'd0, busy, done}, 32'd0);
        halt = 1'b0;

        // 3: backpressure while 111E is held
        push_pass();
        pulse_start();
        steps(2);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_instr", {16'd0, instr}, 32'h111E);
            chk("t3_hold_pc", {24'd0, pc}, 32'd2);
            chk("t3_hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready = 1'b1;
        steps(4);
        chk("t3_loopcnt", {24'd0, loop_cnt}, 32'd1);
        halt = 1'b1;
        steps(2);
        chk("t3_idle", {31'd0, busy}, 32'd0);
        halt = 1'b0;

        // 4: halt with ready low drains the held word, then IDLE
        exp_q.push_back(16'h7132);
        pulse_start();
        step();
        instr_ready = 1'b0; halt = 1'b1;
        step();
        chk("t4_drain_busy", {31'd0, busy}, 32'd1);
        chk("t4_drain_hold", {16'd0, instr}, 32'h7132);
        chk("t4_nofetch_pc", {24'd0, pc}, 32'd1);
        step();
        chk("t4_drain_stay", {31'd0, busy}, 32'd1);
        instr_ready = 1'b1; halt = 1'b0;
        step();
        chk("t4_drained_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_still_drain", {31'd0, busy}, 32'd1);
        step();
        chk("t4_idle", {30'd0, busy, done}, 32'd0);
        start = 1'b1; halt = 1'b1;
        step();
        start = 1'b0; halt = 1'b0;
        step();
        chk("t4_halt_wins", {31'd0, busy}, 32'd0);
        chk("t4_halt_wins_pc", {24'd0, pc}, 32'd1);

        // 2: limit 2 ends in DONE
        loop_limit = 8'd2;
        push_pass(); push_pass();
        pulse_start();
        steps(12);
        chk("t2_drain", {30'd0, busy, done}, 32'd2);
        step();
        chk("t2_done", {30'd0, busy, done}, 32'd1);
        chk("t2_pc", {24'd0, pc}, 32'd0);
        chk("t2_loopcnt", {24'd0, loop_cnt}, 32'd2);
        steps(2);
        chk("t2_done_held", {31'd0, done}, 32'd1);

        // 5: restart from DONE, async reset at pc=3
        loop_limit = 8'd0;
        exp_q.push_back(16'h7132); exp_q.push_back(16'h111E);
        pulse_start();
        chk("t5_restart_busy", {30'd0, busy, done}, 32'd2);
        steps(3);
        chk("t5_pc3", {24'd0, pc}, 32'd3);
        chk("t5_instr", {16'd0, instr}, 32'h111C);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_rst_pc", {24'd0, rom_addr}, 32'd0);
        chk("t5_rst_state", {30'd0, busy, done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 6: all-NOP image, pc wraps without counting a loop
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 256; i++) exp_q.push_back(16'h0000);
        pulse_start();
        steps(255);
        chk("t6_pc255", {24'd0, pc}, 32'd255);
        step();
        chk("t6_pc_wrap", {24'd0, pc}, 32'd0);
        chk("t6_loopcnt", {24'd0, loop_cnt}, 32'd0);
        chk("t6_valid", {31'd0, instr_valid}, 32'd1);
        halt = 1'b1;
        step();
        chk("t6_drain", {31'd0, busy}, 32'd1);
        step();
        chk("t6_idle", {31'd0, busy}, 32'd0);
        halt = 1'b0;
        steps(2);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
